cache_ctrl_2way: RTL and testbench

- Controller that drives the 2-way set-associative cache array (Cache2Way) from the CPU side.
- Accepts single-word CPU load/store requests and checks hit/valid/modify from the array.
- On a miss it writes back a dirty victim line and refills the line from memory over a 128-bit req/ack bus.
- Sits between the pipeline memory stage and Cache2Way/main memory.

---
 rtl/cache_pkg.sv | 57 +++++
 rtl/cache_lru_table.sv | 27 ++
 rtl/cache_ctrl_2way.sv | 229 ++++++++++++++++++++++
 tb/tb_cache_ctrl_2way.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared widths, FSM states, request payload and address helpers for the 2-way cache controller.
package cache_pkg;

  localparam int unsigned ADDR_WIDTH       = 5;
  localparam int unsigned TAG_BITS         = 23;
  localparam int unsigned WHOLE_DATA_WIDTH = 128;
  localparam int unsigned DATA_WORD_NUM    = 4;
  localparam int unsigned DATA_BYTE_NUM    = 4;
  localparam int unsigned CACHE_WAY_NUM    = 2;
  localparam int unsigned WORD_WIDTH       = 32;
  localparam int unsigned CPU_ADDR_WIDTH   = 32;
  localparam int unsigned WORD_SEL_WIDTH   = 2;
  localparam int unsigned BYTE_OFF_WIDTH   = 2;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITE_WAIT,
    WRITEBACK,
    REFILL,
    REFILL_WR
  } state_t;

  typedef struct packed {
    logic [TAG_BITS-1:0]       tag;
    logic [ADDR_WIDTH-1:0]     index;
    logic [WORD_SEL_WIDTH-1:0] word;
    logic [BYTE_OFF_WIDTH-1:0] byte_off;
  } addr_fields_t;

  // Fields of an accepted CPU request that are not already held in arr_addr/arr_tag
  typedef struct packed {
    logic                      we;
    logic [WORD_SEL_WIDTH-1:0] word;
    logic [WORD_WIDTH-1:0]     wdata;
    logic [DATA_BYTE_NUM-1:0]  byte_en;
  } cpu_req_t;

  function automatic addr_fields_t split_addr(input logic [CPU_ADDR_WIDTH-1:0] addr);
    return addr_fields_t'(addr);
  endfunction

  function automatic logic [CPU_ADDR_WIDTH-1:0] line_addr(input logic [TAG_BITS-1:0]   tag,
                                                          input logic [ADDR_WIDTH-1:0] index);
    return {tag, index, 4'b0000};
  endfunction

  function automatic logic [WORD_WIDTH-1:0] line_word(input logic [WHOLE_DATA_WIDTH-1:0] line,
                                                      input logic [WORD_SEL_WIDTH-1:0]   word);
    return line[{word, 5'b00000} +: WORD_WIDTH];
  endfunction

  function automatic logic [CACHE_WAY_NUM-1:0] way_onehot(input logic way);
    return way ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/cache_lru_table.sv
// Per-set 1-bit LRU: holds the way to evict next; cleared asynchronously to way0.
module cache_lru_table
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] index,
  input  logic                  upd_en,
  input  logic                  upd_val,
  output logic                  rd_way_c
);

  localparam int unsigned SETS = 1 << ADDR_WIDTH;

  logic [SETS-1:0] lru;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lru <= '0;
    end else if (upd_en) begin
      lru[index] <= upd_val;
    end
  end

  assign rd_way_c = lru[index];

endmodule

// File: rtl/cache_ctrl_2way.sv
// CPU-side controller for the 2-way set-associative array: hit handling, dirty writeback, line refill.
// Optional CACHE_STATS_EN adds first-pass hit/miss counters (stat_hits, stat_misses).
module cache_ctrl_2way
  import cache_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cpu_req,
  input  logic                          cpu_we,
  input  logic [CPU_ADDR_WIDTH-1:0]     cpu_addr,
  input  logic [WORD_WIDTH-1:0]         cpu_wdata,
  input  logic [DATA_BYTE_NUM-1:0]      cpu_byte_en,
  output logic                          cpu_ready,
  output logic [WORD_WIDTH-1:0]         cpu_rdata,
  output logic [ADDR_WIDTH-1:0]         arr_addr,
  output logic [TAG_BITS-1:0]           arr_tag,
  output logic                          arr_wr_en,
  output logic                          arr_refill,
  output logic [CACHE_WAY_NUM-1:0]      arr_way_select,
  output logic [WHOLE_DATA_WIDTH-1:0]   arr_wr_data,
  output logic [DATA_WORD_NUM-1:0]      arr_wr_word_en,
  output logic [DATA_BYTE_NUM-1:0]      arr_wr_byte_en,
  input  logic [CACHE_WAY_NUM-1:0]      arr_valid,
  input  logic [CACHE_WAY_NUM-1:0]      arr_hit,
  input  logic [CACHE_WAY_NUM-1:0]      arr_modify,
  input  logic [TAG_BITS-1:0]           arr_tag_way0,
  input  logic [TAG_BITS-1:0]           arr_tag_way1,
  input  logic [WHOLE_DATA_WIDTH-1:0]   arr_rd_data_way0,
  input  logic [WHOLE_DATA_WIDTH-1:0]   arr_rd_data_way1,
  input  logic [CACHE_WAY_NUM-1:0]      arr_refill_ready,
  input  logic [CACHE_WAY_NUM-1:0]      arr_write_data_ready,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [CPU_ADDR_WIDTH-1:0]     mem_addr,
  output logic [WHOLE_DATA_WIDTH-1:0]   mem_wdata,
  input  logic [WHOLE_DATA_WIDTH-1:0]   mem_rdata,
  input  logic                          mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                   stat_hits,
  output logic [31:0]                   stat_misses
`endif
);

  state_t       state;
  cpu_req_t     req;
  logic         tgt_way;
  addr_fields_t cpu_f;
  logic         unused_byte_off;
  logic         accept;

  logic [CACHE_WAY_NUM-1:0]    hit_vec;
  logic                        hit;
  logic                        hit_way;
  logic [WHOLE_DATA_WIDTH-1:0] hit_line;
  logic                        lru_way;
  logic                        miss_way;
  logic                        victim_dirty;
  logic [TAG_BITS-1:0]         victim_tag;
  logic [WHOLE_DATA_WIDTH-1:0] victim_line;
  logic                        lru_upd;

  assign cpu_f           = split_addr(cpu_addr);
  assign unused_byte_off = ^cpu_f.byte_off;
  // cpu_req is still the completed request during the cpu_ready cycle
  assign accept          = cpu_req && !cpu_ready;

  // Hit/victim decision from the array's combinational status
  always_comb begin
    hit_vec  = arr_hit & arr_valid;
    hit      = |hit_vec;
    hit_way  = !hit_vec[0];
    hit_line = hit_way ? arr_rd_data_way1 : arr_rd_data_way0;
    if (!arr_valid[0]) begin
      miss_way = 1'b0;
    end else if (!arr_valid[1]) begin
      miss_way = 1'b1;
    end else begin
      miss_way = lru_way;
    end
    victim_dirty = arr_valid[miss_way] && arr_modify[miss_way];
    victim_tag   = miss_way ? arr_tag_way1 : arr_tag_way0;
    victim_line  = miss_way ? arr_rd_data_way1 : arr_rd_data_way0;
  end

  assign lru_upd = (state == COMPARE) && hit;

  cache_lru_table u_lru (
    .clk      (clk),
    .rst      (rst),
    .index    (arr_addr),
    .upd_en   (lru_upd),
    .upd_val  (!hit_way),
    .rd_way_c (lru_way)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      req            <= '0;
      tgt_way        <= 1'b0;
      cpu_ready      <= 1'b0;
      cpu_rdata      <= '0;
      arr_addr       <= '0;
      arr_tag        <= '0;
      arr_wr_en      <= 1'b0;
      arr_refill     <= 1'b0;
      arr_way_select <= '0;
      arr_wr_data    <= '0;
      arr_wr_word_en <= '0;
      arr_wr_byte_en <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      cpu_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            req      <= '{we: cpu_we, word: cpu_f.word, wdata: cpu_wdata, byte_en: cpu_byte_en};
            arr_addr <= cpu_f.index;
            arr_tag  <= cpu_f.tag;
            state    <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            tgt_way <= hit_way;
            if (req.we) begin
              arr_wr_en      <= 1'b1;
              arr_way_select <= way_onehot(hit_way);
              arr_wr_word_en <= 4'b0001 << req.word;
              arr_wr_byte_en <= req.byte_en;
              arr_wr_data    <= {DATA_WORD_NUM{req.wdata}};
              state          <= WRITE_WAIT;
            end else begin
              cpu_ready <= 1'b1;
              cpu_rdata <= line_word(hit_line, req.word);
              state     <= IDLE;
            end
          end else begin
            tgt_way <= miss_way;
            mem_req <= 1'b1;
            if (victim_dirty) begin
              mem_we    <= 1'b1;
              mem_addr  <= line_addr(victim_tag, arr_addr);
              mem_wdata <= victim_line;
              state     <= WRITEBACK;
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= line_addr(arr_tag, arr_addr);
              state    <= REFILL;
            end
          end
        end
        WRITE_WAIT: begin
          if (arr_write_data_ready[tgt_way]) begin
            arr_wr_en      <= 1'b0;
            arr_way_select <= '0;
            arr_wr_word_en <= '0;
            arr_wr_byte_en <= '0;
            cpu_ready      <= 1'b1;
            state          <= IDLE;
          end
        end
        WRITEBACK: begin
          // mem_req stays high straight into the refill request
          if (mem_ack) begin
            mem_we    <= 1'b0;
            mem_addr  <= line_addr(arr_tag, arr_addr);
            mem_wdata <= '0;
            state     <= REFILL;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            mem_req        <= 1'b0;
            arr_refill     <= 1'b1;
            arr_wr_en      <= 1'b1;
            arr_way_select <= way_onehot(tgt_way);
            arr_wr_data    <= mem_rdata;
            arr_wr_word_en <= '1;
            arr_wr_byte_en <= '1;
            state          <= REFILL_WR;
          end
        end
        REFILL_WR: begin
          if (arr_refill_ready[tgt_way]) begin
            arr_refill     <= 1'b0;
            arr_wr_en      <= 1'b0;
            arr_way_select <= '0;
            arr_wr_word_en <= '0;
            arr_wr_byte_en <= '0;
            state          <= COMPARE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic first_pass;

  // Only the first COMPARE after acceptance counts; the post-refill re-compare is skipped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_pass  <= 1'b0;
      stat_hits   <= '0;
      stat_misses <= '0;
    end else begin
      if (state == IDLE && accept) begin
        first_pass <= 1'b1;
      end else if (state == COMPARE) begin
        first_pass <= 1'b0;
        if (first_pass) begin
          if (hit) begin
            stat_hits <= stat_hits + 32'd1;
          end else begin
            stat_misses <= stat_misses + 32'd1;
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Directed bench for cache_ctrl_2way with a behavioural 2-way array and a scoreboarded memory.
module tb_cache_ctrl_2way;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cpu_req = 1'b0;
  logic         cpu_we = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [3:0]   cpu_byte_en = '0;
  logic         cpu_ready;
  logic [31:0]  cpu_rdata;
  logic [4:0]   arr_addr;
  logic [22:0]  arr_tag;
  logic         arr_wr_en;
  logic         arr_refill;
  logic [1:0]   arr_way_select;
  logic [127:0] arr_wr_data;
  logic [3:0]   arr_wr_word_en;
  logic [3:0]   arr_wr_byte_en;
  logic [1:0]   arr_valid;
  logic [1:0]   arr_hit;
  logic [1:0]   arr_modify;
  logic [22:0]  arr_tag_way0;
  logic [22:0]  arr_tag_way1;
  logic [127:0] arr_rd_data_way0;
  logic [127:0] arr_rd_data_way1;
  logic [1:0]   arr_refill_ready = '0;
  logic [1:0]   arr_write_data_ready = '0;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;
`ifdef CACHE_STATS_EN
  logic [31:0]  stat_hits;
  logic [31:0]  stat_misses;
`endif

  cache_ctrl_2way dut (
    .clk                  (clk),
    .rst                  (rst),
    .cpu_req              (cpu_req),
    .cpu_we               (cpu_we),
    .cpu_addr             (cpu_addr),
    .cpu_wdata            (cpu_wdata),
    .cpu_byte_en          (cpu_byte_en),
    .cpu_ready            (cpu_ready),
    .cpu_rdata            (cpu_rdata),
    .arr_addr             (arr_addr),
    .arr_tag              (arr_tag),
    .arr_wr_en            (arr_wr_en),
    .arr_refill           (arr_refill),
    .arr_way_select       (arr_way_select),
    .arr_wr_data          (arr_wr_data),
    .arr_wr_word_en       (arr_wr_word_en),
    .arr_wr_byte_en       (arr_wr_byte_en),
    .arr_valid            (arr_valid),
    .arr_hit              (arr_hit),
    .arr_modify           (arr_modify),
    .arr_tag_way0         (arr_tag_way0),
    .arr_tag_way1         (arr_tag_way1),
    .arr_rd_data_way0     (arr_rd_data_way0),
    .arr_rd_data_way1     (arr_rd_data_way1),
    .arr_refill_ready     (arr_refill_ready),
    .arr_write_data_ready (arr_write_data_ready),
    .mem_req              (mem_req),
    .mem_we               (mem_we),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_rdata            (mem_rdata),
    .mem_ack              (mem_ack)
`ifdef CACHE_STATS_EN
    ,
    .stat_hits            (stat_hits),
    .stat_misses          (stat_misses)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct { logic is_load; logic [31:0] rdata; } sb_t;
  typedef struct { logic we; logic [31:0] addr; logic [127:0] wdata; } mem_t;
  sb_t          sb_q[$];
  mem_t         mem_q[$];
  logic [127:0] wb_store [bit [31:0]];

  int           lat;
  int           nmem;
  logic [1:0]   obs_ref_sel;
  logic [22:0]  obs_ref_tag;
  logic [1:0]   obs_st_sel;
  logic [3:0]   obs_st_word;
  logic [3:0]   obs_st_byte;
  logic [127:0] obs_st_data;

  // Behavioural array: status is combinational from arr_addr/arr_tag, writes complete in one cycle
  logic [22:0]       m_tag  [2][32];
  logic [127:0]      m_data [2][32];
  logic [1:0][31:0]  m_valid = '0;
  logic [1:0][31:0]  m_dirty = '0;

  always_comb begin
    for (int w = 0; w < 2; w++) begin
      arr_valid[w]  = m_valid[w][arr_addr];
      arr_modify[w] = m_dirty[w][arr_addr];
      arr_hit[w]    = (m_tag[w][arr_addr] == arr_tag);
    end
    arr_tag_way0     = m_tag[0][arr_addr];
    arr_tag_way1     = m_tag[1][arr_addr];
    arr_rd_data_way0 = m_data[0][arr_addr];
    arr_rd_data_way1 = m_data[1][arr_addr];
  end

  function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] nw,
                                         input logic [3:0] wen, input logic [3:0] ben);
    logic [127:0] r;
    r = old;
    for (int b = 0; b < 16; b++)
      if (wen[b / 4] && ben[b % 4]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    arr_refill_ready     <= 2'b00;
    arr_write_data_ready <= 2'b00;
    if (arr_wr_en && ((arr_refill_ready | arr_write_data_ready) == 2'b00)) begin
      for (int w = 0; w < 2; w++) begin
        if (arr_way_select[w]) begin
          if (arr_refill) begin
            m_tag[w][arr_addr]   <= arr_tag;
            m_data[w][arr_addr]  <= arr_wr_data;
            m_valid[w][arr_addr] <= 1'b1;
            m_dirty[w][arr_addr] <= 1'b0;
          end else begin
            m_data[w][arr_addr]  <= merge(m_data[w][arr_addr], arr_wr_data, arr_wr_word_en, arr_wr_byte_en);
            m_dirty[w][arr_addr] <= 1'b1;
          end
        end
      end
      if (arr_refill) arr_refill_ready <= arr_way_select;
      else            arr_write_data_ready <= arr_way_select;
    end
  end

  function automatic logic [127:0] gen_line(input logic [31:0] a);
    return {a ^ 32'h3C3C_0003, a ^ 32'h5A5A_0002, a ^ 32'h9696_0001, a ^ 32'hC3C3_0000};
  endfunction

  function automatic void chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  // One CPU access; services memory from mem_q and pops the scoreboard on cpu_ready
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rdata);
    logic done;
    mem_t m;
    sb_t  s;
    @(negedge clk);
    sb_q.push_back('{is_load: !we, rdata: exp_rdata});
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_byte_en = be;
    done = 1'b0; lat = 0; nmem = 0;
    obs_ref_sel = '0; obs_ref_tag = '0; obs_st_sel = '0;
    obs_st_word = '0; obs_st_byte = '0; obs_st_data = '0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      lat++;
      mem_ack = 1'b0;
      if (arr_wr_en && arr_refill) begin
        obs_ref_sel = arr_way_select;
        obs_ref_tag = arr_tag;
      end
      if (arr_wr_en && !arr_refill) begin
        obs_st_sel  = arr_way_select;
        obs_st_word = arr_wr_word_en;
        obs_st_byte = arr_wr_byte_en;
        obs_st_data = arr_wr_data;
      end
      if (cpu_ready) begin
        done = 1'b1;
        cpu_req = 1'b0;
        chk("sb_pending", 128'(sb_q.size() != 0), 128'd1);
        if (sb_q.size() != 0) begin
          s = sb_q.pop_front();
          if (s.is_load) chk("cpu_rdata", 128'(cpu_rdata), 128'(s.rdata));
        end
      end else if (mem_req) begin
        nmem++;
        chk("mem_expected", 128'(mem_q.size() != 0), 128'd1);
        if (mem_q.size() != 0) begin
          m = mem_q.pop_front();
          chk("mem_we", 128'(mem_we), 128'(m.we));
          chk("mem_addr", 128'(mem_addr), 128'(m.addr));
          if (m.we) begin
            chk("mem_wdata", mem_wdata, m.wdata);
            wb_store[mem_addr] = mem_wdata;
          end
        end
        mem_rdata = wb_store.exists(mem_addr) ? wb_store[mem_addr] : gen_line(mem_addr);
        mem_ack = 1'b1;
      end
    end
    chk("cpu_ready_timeout", 128'(done), 128'd1);
  endtask

  logic [127:0] l40, l40m, l240, l440, l640, l1000;

  initial begin
    l40   = gen_line(32'h0000_0040);
    l240  = gen_line(32'h0000_0240);
    l440  = gen_line(32'h0000_0440);
    l640  = gen_line(32'h0000_0640);
    l1000 = gen_line(32'h0000_1000);
    l40m  = l40;
    l40m[79:64] = 16'hBEEF;

    repeat (2) @(negedge clk);
    chk("rst_cpu_ready", 128'(cpu_ready), 128'd0);
    chk("rst_mem_req", 128'(mem_req), 128'd0);
    chk("rst_arr_wr_en", 128'(arr_wr_en), 128'd0);
    chk("rst_way_select", 128'(arr_way_select), 128'd0);
    chk("rst_mem_addr", 128'(mem_addr), 128'd0);
    rst = 1'b1;

    // Cold miss: refill into way0
    mem_q.push_back('{we: 1'b0, addr: 32'h40, wdata: '0});
    access(1'b0, 32'h40, 32'h0, 4'h0, l40[31:0]);
    chk("t1_nmem", 128'(nmem), 128'd1);
    chk("t1_ref_sel", 128'(obs_ref_sel), 128'd1);
    chk("t1_ref_tag", 128'(obs_ref_tag), 128'd0);

    // Load hit: ready one cycle after acceptance
    access(1'b0, 32'h44, 32'h0, 4'h0, l40[63:32]);
    chk("t2_lat", 128'(lat), 128'd2);
    chk("t2_nmem", 128'(nmem), 128'd0);

    // Store hit with partial byte enables
    access(1'b1, 32'h48, 32'hDEAD_BEEF, 4'b0011, 32'h0);
    chk("t3_nmem", 128'(nmem), 128'd0);
    chk("t3_sel", 128'(obs_st_sel), 128'd1);
    chk("t3_word_en", 128'(obs_st_word), 128'h4);
    chk("t3_byte_en", 128'(obs_st_byte), 128'h3);
    chk("t3_wr_data", obs_st_data, {4{32'hDEAD_BEEF}});

    // Second tag in set 4 fills way1
    mem_q.push_back('{we: 1'b0, addr: 32'h240, wdata: '0});
    access(1'b0, 32'h240, 32'h0, 4'h0, l240[31:0]);
    chk("t4_nmem", 128'(nmem), 128'd1);
    chk("t4_ref_sel", 128'(obs_ref_sel), 128'd2);
    chk("t4_ref_tag", 128'(obs_ref_tag), 128'd1);

    // Third tag evicts dirty LRU way0: writeback then refill
    mem_q.push_back('{we: 1'b1, addr: 32'h40, wdata: l40m});
    mem_q.push_back('{we: 1'b0, addr: 32'h440, wdata: '0});
    access(1'b0, 32'h440, 32'h0, 4'h0, l440[31:0]);
    chk("t5_nmem", 128'(nmem), 128'd2);
    chk("t5_ref_sel", 128'(obs_ref_sel), 128'd1);
    chk("t5_ref_tag", 128'(obs_ref_tag), 128'd2);

    // Hit way1 so way0 becomes LRU
    access(1'b0, 32'h24C, 32'h0, 4'h0, l240[127:96]);
    chk("t6_lat", 128'(lat), 128'd2);
    chk("t6_nmem", 128'(nmem), 128'd0);

    // Clean victim way0: refill only
    mem_q.push_back('{we: 1'b0, addr: 32'h640, wdata: '0});
    access(1'b0, 32'h640, 32'h0, 4'h0, l640[31:0]);
    chk("t7_nmem", 128'(nmem), 128'd1);
    chk("t7_ref_sel", 128'(obs_ref_sel), 128'd1);
    chk("t7_ref_tag", 128'(obs_ref_tag), 128'd3);

    // Refetch the written-back line into way1; store data must survive
    mem_q.push_back('{we: 1'b0, addr: 32'h40, wdata: '0});
    access(1'b0, 32'h48, 32'h0, 4'h0, l40m[95:64]);
    chk("t8_nmem", 128'(nmem), 128'd1);
    chk("t8_ref_sel", 128'(obs_ref_sel), 128'd2);

`ifdef CACHE_STATS_EN
    chk("stat_hits", 128'(stat_hits), 128'd3);
    chk("stat_misses", 128'(stat_misses), 128'd5);
`endif

    // Reset while the refill request is outstanding
    @(negedge clk);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1000; cpu_wdata = '0; cpu_byte_en = '0;
    for (int c = 0; c < 20 && !mem_req; c++) @(negedge clk);
    chk("t9_mem_req_seen", 128'(mem_req), 128'd1);
    rst = 1'b0;
    #1;
    chk("t9_rst_mem_req", 128'(mem_req), 128'd0);
    chk("t9_rst_arr_addr", 128'(arr_addr), 128'd0);
    chk("t9_rst_cpu_ready", 128'(cpu_ready), 128'd0);
`ifdef CACHE_STATS_EN
    chk("t9_rst_stat_misses", 128'(stat_misses), 128'd0);
`endif
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    mem_q.push_back('{we: 1'b0, addr: 32'h1000, wdata: '0});
    access(1'b0, 32'h1000, 32'h0, 4'h0, l1000[31:0]);
    chk("t10_nmem", 128'(nmem), 128'd1);
    chk("t10_ref_sel", 128'(obs_ref_sel), 128'd1);
    chk("t10_ref_tag", 128'(obs_ref_tag), 128'd8);

`ifdef CACHE_STATS_EN
    chk("t10_stat_hits", 128'(stat_hits), 128'd0);
    chk("t10_stat_misses", 128'(stat_misses), 128'd1);
`endif

    chk("sb_drained", 128'(sb_q.size()), 128'd0);
    chk("mem_q_drained", 128'(mem_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
